gemm_result_drain: RTL and testbench

//  Reads packed GEMM output tiles (RowPar x ColPar x OutDataWidth words) from the C SRAM.

---
 rtl/gemm_pkg.sv | 30 +++
 rtl/gemm_drain_tile_buf.sv | 98 +++++++++
 rtl/gemm_result_drain.sv | 143 ++++++++++++++
 tb/tb_gemm_result_drain.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared constants, drain FSM state type and MSB-first tile unpack helper for the GEMM result drain.
// Tile geometry is fixed here. The optional second tile buffer is enabled by GEMM_DRAIN_PREFETCH_EN.
package gemm_pkg;

   localparam int OutDataWidth   = 32;
   localparam int RowPar         = 4;
   localparam int ColPar         = 16;
   localparam int AddrWidth      = 12;
   localparam int SizeAddrWidth  = 32;
   localparam int TileSize       = RowPar * ColPar;
   localparam int PackedOutWidth = TileSize * OutDataWidth;
   localparam int ElemIdxWidth   = $clog2(TileSize);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      STREAM,
      DONE
   } drain_state_e;

   // Element 0 (row 0, column 0) occupies the most significant word of the packed tile.
   function automatic logic [OutDataWidth-1:0] unpack_elem(
      input logic [PackedOutWidth-1:0] tile,
      input logic [ElemIdxWidth-1:0]   idx
   );
      return tile[(TileSize - 1 - int'(idx)) * OutDataWidth +: OutDataWidth];
   endfunction

endpackage

// File: rtl/gemm_drain_tile_buf.sv
// Tile buffer(s), element counter and output stream mux/flags for the GEMM result drain.
// With GEMM_DRAIN_PREFETCH_EN a second buffer holds the next tile so tiles stream back-to-back.
module gemm_drain_tile_buf
   import gemm_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [PackedOutWidth-1:0] rdata_i,
   input  logic                      load_i,
`ifdef GEMM_DRAIN_PREFETCH_EN
   input  logic                      load_nxt_i,
   output logic                      nxt_full_o,
`endif
   input  logic                      last_tile_i,
   input  logic                      out_ready_i,
   output logic [OutDataWidth-1:0]   out_data_o,
   output logic                      out_valid_o,
   output logic                      out_tile_last_o,
   output logic                      out_last_o,
   output logic                      tile_done_o
);

   logic [PackedOutWidth-1:0] cur_tile_reg, cur_tile_next;
   logic [ElemIdxWidth-1:0]   elem_cnt_reg, elem_cnt_next;
   logic                      cur_valid_reg, cur_valid_next;
   logic                      beat_xfer;
   logic                      elem_is_last;

`ifdef GEMM_DRAIN_PREFETCH_EN
   logic [PackedOutWidth-1:0] nxt_tile_reg, nxt_tile_next;
   logic                      nxt_full_reg, nxt_full_next;

   assign nxt_full_o = nxt_full_reg;
`endif

   assign elem_is_last    = (elem_cnt_reg == ElemIdxWidth'(TileSize - 1));
   assign beat_xfer       = cur_valid_reg & out_ready_i;
   assign tile_done_o     = beat_xfer & elem_is_last;
   assign out_valid_o     = cur_valid_reg;
   assign out_data_o      = unpack_elem(cur_tile_reg, elem_cnt_reg);
   assign out_tile_last_o = cur_valid_reg & elem_is_last;
   assign out_last_o      = out_tile_last_o & last_tile_i;

   always_comb begin
      cur_tile_next  = cur_tile_reg;
      elem_cnt_next  = elem_cnt_reg;
      cur_valid_next = cur_valid_reg;
`ifdef GEMM_DRAIN_PREFETCH_EN
      nxt_tile_next  = nxt_tile_reg;
      nxt_full_next  = nxt_full_reg;
      if (load_nxt_i) begin
         nxt_tile_next = rdata_i;
         nxt_full_next = 1'b1;
      end
`endif
      if (load_i) begin
         cur_tile_next  = rdata_i;
         elem_cnt_next  = '0;
         cur_valid_next = 1'b1;
      end else if (tile_done_o) begin
         elem_cnt_next = '0;
`ifdef GEMM_DRAIN_PREFETCH_EN
         // Swap in the prefetched tile without dropping valid.
         if (nxt_full_reg) begin
            cur_tile_next = nxt_tile_reg;
            nxt_full_next = 1'b0;
         end else begin
            cur_valid_next = 1'b0;
         end
`else
         cur_valid_next = 1'b0;
`endif
      end else if (beat_xfer) begin
         elem_cnt_next = elem_cnt_reg + ElemIdxWidth'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cur_tile_reg  <= '0;
         elem_cnt_reg  <= '0;
         cur_valid_reg <= 1'b0;
`ifdef GEMM_DRAIN_PREFETCH_EN
         nxt_tile_reg  <= '0;
         nxt_full_reg  <= 1'b0;
`endif
      end else begin
         cur_tile_reg  <= cur_tile_next;
         elem_cnt_reg  <= elem_cnt_next;
         cur_valid_reg <= cur_valid_next;
`ifdef GEMM_DRAIN_PREFETCH_EN
         nxt_tile_reg  <= nxt_tile_next;
         nxt_full_reg  <= nxt_full_next;
`endif
      end
   end

endmodule

// File: rtl/gemm_result_drain.sv
// Drains packed GEMM result tiles from the C SRAM and streams them as single elements.
// Define GEMM_DRAIN_PREFETCH_EN to overlap the next tile's SRAM read with streaming.
module gemm_result_drain
   import gemm_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      start_i,
   input  logic [AddrWidth-1:0]      base_addr_i,
   input  logic [SizeAddrWidth-1:0]  num_tiles_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [AddrWidth-1:0]      sram_c_addr_o,
   input  logic [PackedOutWidth-1:0] sram_c_rdata_i,
   output logic [OutDataWidth-1:0]   out_data_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic                      out_tile_last_o,
   output logic                      out_last_o
);

   drain_state_e             state_reg, state_next;
   logic [AddrWidth-1:0]     addr_reg, addr_next;
   logic [SizeAddrWidth-1:0] tiles_left_reg, tiles_left_next;
   logic                     load_cur;
   logic                     tile_done;
   logic                     last_tile;

`ifdef GEMM_DRAIN_PREFETCH_EN
   logic [SizeAddrWidth-1:0] issue_left_reg, issue_left_next;
   logic                     rd_issued_reg, rd_issued_next;
   logic                     rd_data_reg, rd_data_next;
   logic                     nxt_full;
   logic                     issue_rd;
`endif

   assign sram_c_addr_o = addr_reg;
   assign busy_o        = (state_reg == FETCH) || (state_reg == LOAD) || (state_reg == STREAM);
   assign done_o        = (state_reg == DONE);
   assign last_tile     = (tiles_left_reg == SizeAddrWidth'(1));

   always_comb begin
      state_next      = state_reg;
      addr_next       = addr_reg;
      tiles_left_next = tiles_left_reg;
      load_cur        = 1'b0;
`ifdef GEMM_DRAIN_PREFETCH_EN
      issue_left_next = issue_left_reg;
      issue_rd        = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (start_i) begin
               if (num_tiles_i != '0) begin
                  state_next      = FETCH;
                  addr_next       = base_addr_i;
                  tiles_left_next = num_tiles_i;
`ifdef GEMM_DRAIN_PREFETCH_EN
                  issue_left_next = num_tiles_i - SizeAddrWidth'(1);
`endif
               end else begin
                  state_next = DONE;
               end
            end
         end
         FETCH: state_next = LOAD;
         LOAD: begin
            load_cur   = 1'b1;
            state_next = STREAM;
         end
         STREAM: begin
`ifdef GEMM_DRAIN_PREFETCH_EN
            // One outstanding read at a time, only while the spare buffer is free.
            if ((issue_left_reg != '0) && !nxt_full && !rd_issued_reg && !rd_data_reg) begin
               issue_rd        = 1'b1;
               addr_next       = addr_reg + AddrWidth'(1);
               issue_left_next = issue_left_reg - SizeAddrWidth'(1);
            end
`endif
            if (tile_done) begin
               tiles_left_next = tiles_left_reg - SizeAddrWidth'(1);
               if (last_tile) begin
                  state_next = DONE;
               end else begin
`ifndef GEMM_DRAIN_PREFETCH_EN
                  state_next = FETCH;
                  addr_next  = addr_reg + AddrWidth'(1);
`endif
               end
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

`ifdef GEMM_DRAIN_PREFETCH_EN
   // Read data is valid two edges after the address register updates, as in FETCH/LOAD.
   assign rd_issued_next = issue_rd;
   assign rd_data_next   = rd_issued_reg;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg      <= IDLE;
         addr_reg       <= '0;
         tiles_left_reg <= '0;
`ifdef GEMM_DRAIN_PREFETCH_EN
         issue_left_reg <= '0;
         rd_issued_reg  <= 1'b0;
         rd_data_reg    <= 1'b0;
`endif
      end else begin
         state_reg      <= state_next;
         addr_reg       <= addr_next;
         tiles_left_reg <= tiles_left_next;
`ifdef GEMM_DRAIN_PREFETCH_EN
         issue_left_reg <= issue_left_next;
         rd_issued_reg  <= rd_issued_next;
         rd_data_reg    <= rd_data_next;
`endif
      end
   end

   gemm_drain_tile_buf u_tile_buf (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .rdata_i         (sram_c_rdata_i),
      .load_i          (load_cur),
`ifdef GEMM_DRAIN_PREFETCH_EN
      .load_nxt_i      (rd_data_reg),
      .nxt_full_o      (nxt_full),
`endif
      .last_tile_i     (last_tile),
      .out_ready_i     (out_ready_i),
      .out_data_o      (out_data_o),
      .out_valid_o     (out_valid_o),
      .out_tile_last_o (out_tile_last_o),
      .out_last_o      (out_last_o),
      .tile_done_o     (tile_done)
   );

endmodule

// File: tb/tb_gemm_result_drain.sv
// Randomized self-checking bench for gemm_result_drain: SRAM model, element-level expected queue.
// Expected drain latency follows GEMM_DRAIN_PREFETCH_EN when it is defined for the build.
module tb_gemm_result_drain;

   localparam int OW = 32;
   localparam int TS = 64;
   localparam int AW = 12;
   localparam int NW = 32;
   localparam int PW = TS * OW;
`ifdef GEMM_DRAIN_PREFETCH_EN
   localparam int GAP = 0;
`else
   localparam int GAP = 2;
`endif

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          start_i = 1'b0;
   logic [AW-1:0] base_addr_i = '0;
   logic [NW-1:0] num_tiles_i = '0;
   logic          busy_o;
   logic          done_o;
   logic [AW-1:0] sram_c_addr_o;
   logic [PW-1:0] sram_c_rdata_i = '0;
   logic [OW-1:0] out_data_o;
   logic          out_valid_o;
   logic          out_ready_i = 1'b1;
   logic          out_tile_last_o;
   logic          out_last_o;

   gemm_result_drain dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .start_i         (start_i),
      .base_addr_i     (base_addr_i),
      .num_tiles_i     (num_tiles_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .sram_c_addr_o   (sram_c_addr_o),
      .sram_c_rdata_i  (sram_c_rdata_i),
      .out_data_o      (out_data_o),
      .out_valid_o     (out_valid_o),
      .out_ready_i     (out_ready_i),
      .out_tile_last_o (out_tile_last_o),
      .out_last_o      (out_last_o)
   );

   initial forever #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [OW-1:0] data;
      logic          tile_last;
      logic          last;
   } beat_t;

   logic [OW-1:0] elems [0:4095][0:TS-1];
   beat_t         exp_q[$];
   int            addr_log[$];
   int            n_checks = 0;
   int            n_pass = 0;
   int            cyc = 0;
   int            start_edge = 0;
   int            beats_seen = 0;
   int            valid_cycles = 0;
   int            tile_last_seen = 0;
   int            done_seen = 0;
   int            done_cyc = -1;
   int            last_xfer_edge = -1;
   bit            rand_ready = 1'b0;
   logic [OW-1:0] first_data = '0;
   logic [OW-1:0] beat63_data = '0;
   logic          beat63_tl = 1'b0;
   logic          beat63_last = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Tiles are stored element-wise; the SRAM packs element 0 at the MSB.
   function automatic logic [PW-1:0] pack_tile(input int a);
      logic [PW-1:0] w = '0;
      for (int i = 0; i < TS; i++) w[(TS-1-i)*OW +: OW] = elems[a][i];
      return w;
   endfunction

   initial forever begin
      @(posedge clk_i);
      sram_c_rdata_i <= pack_tile(int'(sram_c_addr_o));
   end

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   initial forever begin
      @(posedge clk_i);
      #1;
      out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: stall stability, beat order/flags, done timing, address changes.
   beat_t         cur_b;
   beat_t         prev_b;
   beat_t         exp_b;
   logic          prev_stall = 1'b0;
   logic [AW-1:0] last_addr = '0;
   initial forever begin
      @(negedge clk_i);
      if (sram_c_addr_o != last_addr) begin
         addr_log.push_back(int'(sram_c_addr_o));
         last_addr = sram_c_addr_o;
      end
      if (!rst_ni) begin
         prev_stall = 1'b0;
      end else begin
         cur_b = '{out_data_o, out_tile_last_o, out_last_o};
         if (prev_stall) begin
            chk("stall_valid", 64'(out_valid_o), 64'd1);
            chk("stall_hold", 64'(cur_b), 64'(prev_b));
         end
         if (out_valid_o) valid_cycles++;
         if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", out_data_o);
            end else begin
               exp_b = exp_q.pop_front();
               chk("beat_data", 64'(out_data_o), 64'(exp_b.data));
               chk("beat_tile_last", 64'(out_tile_last_o), 64'(exp_b.tile_last));
               chk("beat_last", 64'(out_last_o), 64'(exp_b.last));
            end
            if (beats_seen == 0) first_data = out_data_o;
            if (beats_seen == 63) begin
               beat63_data = out_data_o;
               beat63_tl   = out_tile_last_o;
               beat63_last = out_last_o;
            end
            beats_seen++;
            if (out_tile_last_o) tile_last_seen++;
            if (out_last_o) last_xfer_edge = cyc + 1;
         end
         prev_stall = out_valid_o && !out_ready_i;
         prev_b     = cur_b;
         if (done_o) begin
            done_seen++;
            done_cyc = cyc;
         end
      end
   end

   task automatic fill_random(input int base, input int n);
      for (int t = 0; t < n; t++)
         for (int i = 0; i < TS; i++) elems[(base + t) % 4096][i] = $urandom;
   endtask

   task automatic start_drain(input int base, input int n);
      for (int t = 0; t < n; t++)
         for (int i = 0; i < TS; i++)
            exp_q.push_back('{elems[(base + t) % 4096][i], i == TS-1, (t == n-1) && (i == TS-1)});
      @(posedge clk_i);
      #1;
      addr_log.delete();
      base_addr_i = AW'(base);
      num_tiles_i = NW'(n);
      start_i     = 1'b1;
      @(posedge clk_i);
      #1;
      start_edge  = cyc;
      start_i     = 1'b0;
      base_addr_i = AW'($urandom);
      num_tiles_i = NW'($urandom_range(1, 8));
   endtask

   task automatic wait_done(input string name, input int n, input bit timed);
      bit seen = 1'b0;
      for (int k = 0; k < 20000 && !seen; k++) begin
         @(negedge clk_i);
         #1;
         if (done_o) seen = 1'b1;
      end
      if (!seen) begin
         n_checks++;
         $display("FAIL %s_done_timeout: got no done_o, expected done_o", name);
         return;
      end
      chk({name, "_busy_at_done"}, 64'(busy_o), 64'd0);
      chk({name, "_done_cycle"}, 64'(done_cyc), 64'(n == 0 ? start_edge : last_xfer_edge));
      chk({name, "_all_beats"}, 64'(exp_q.size()), 64'd0);
      if (timed)
         chk({name, "_latency"}, 64'(last_xfer_edge - start_edge), 64'(2 + n*TS + GAP*(n-1)));
      @(negedge clk_i);
      #1;
      chk({name, "_done_one_cycle"}, 64'(done_o), 64'd0);
   endtask

   int            b0;
   int            d0;
   int            v0;
   logic [AW-1:0] a0;

   initial begin
      // Reset state
      repeat (3) @(negedge clk_i);
      #1;
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_valid", 64'(out_valid_o), 64'd0);
      chk("rst_addr", 64'(sram_c_addr_o), 64'd0);
      chk("rst_data", 64'(out_data_o), 64'd0);
      chk("rst_flags", 64'({out_tile_last_o, out_last_o}), 64'd0);
      rst_ni = 1'b1;

      // 1: one tile at 0, element i = 0x1000+i, ready high
      for (int i = 0; i < TS; i++) elems[0][i] = 32'h1000 + i;
      start_drain(0, 1);
      wait_done("t1", 1, 1'b1);
      chk("t1_first_beat", 64'(first_data), 64'h1000);
      chk("t1_beat63", 64'(beat63_data), 64'h103F);
      chk("t1_beat63_flags", 64'({beat63_tl, beat63_last}), 64'b11);
      chk("t1_latency_abs", 64'(last_xfer_edge - start_edge), 64'd66);
      $display("t1: 1 tile drained, beats=%0d", beats_seen);

      // 2: 16 random tiles, random ready
      fill_random(100, 16);
      rand_ready = 1'b1;
      v0 = tile_last_seen;
      b0 = beats_seen;
      start_drain(100, 16);
      wait_done("t2", 16, 1'b0);
      rand_ready = 1'b0;
      chk("t2_beats", 64'(beats_seen - b0), 64'd1024);
      chk("t2_tile_lasts", 64'(tile_last_seen - v0), 64'd16);
      $display("t2: 16 tiles with random ready drained");

      // 3: zero tiles
      a0 = sram_c_addr_o;
      v0 = valid_cycles;
      start_drain(7, 0);
      wait_done("t3", 0, 1'b0);
      chk("t3_no_valid", 64'(valid_cycles - v0), 64'd0);
      chk("t3_addr_held", 64'(sram_c_addr_o), 64'(a0));
      $display("t3: zero-tile drain");

      // 4: address wrap
      fill_random(4094, 4);
      start_drain(4094, 4);
      wait_done("t4", 4, 1'b1);
      chk("t4_nreads", 64'(addr_log.size()), 64'd4);
      if (addr_log.size() == 4) begin
         chk("t4_addr0", 64'(addr_log[0]), 64'd4094);
         chk("t4_addr1", 64'(addr_log[1]), 64'd4095);
         chk("t4_addr2", 64'(addr_log[2]), 64'd0);
         chk("t4_addr3", 64'(addr_log[3]), 64'd1);
      end
      $display("t4: wrap drain, reads=%0d", addr_log.size());

      // 5: async reset at beat 20 of tile 1, then a fresh drain
      fill_random(200, 3);
      fill_random(300, 2);
      b0 = beats_seen;
      start_drain(200, 3);
      for (int k = 0; k < 1000 && (beats_seen - b0) < 84; k++) begin
         @(negedge clk_i);
         #1;
      end
      chk("t5_reached_beat84", 64'(beats_seen - b0), 64'd84);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("t5_rst_valid", 64'(out_valid_o), 64'd0);
      chk("t5_rst_busy", 64'(busy_o), 64'd0);
      chk("t5_rst_done", 64'(done_o), 64'd0);
      chk("t5_rst_addr", 64'(sram_c_addr_o), 64'd0);
      chk("t5_rst_data", 64'(out_data_o), 64'd0);
      chk("t5_rst_flags", 64'({out_tile_last_o, out_last_o}), 64'd0);
      exp_q.delete();
      d0 = done_seen;
      repeat (3) @(negedge clk_i);
      #1;
      rst_ni = 1'b1;
      repeat (3) @(negedge clk_i);
      #1;
      chk("t5_no_done", 64'(done_seen - d0), 64'd0);
      start_drain(300, 2);
      wait_done("t5b", 2, 1'b1);
      $display("t5: reset mid-drain then fresh 2-tile drain");

      // 6: start mid-drain is ignored
      fill_random(400, 2);
      fill_random(500, 5);
      start_drain(400, 2);
      repeat (10) @(posedge clk_i);
      #1;
      base_addr_i = AW'(500);
      num_tiles_i = NW'(5);
      start_i     = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      wait_done("t6", 2, 1'b1);
      chk("t6_nreads", 64'(addr_log.size()), 64'd2);
      if (addr_log.size() == 2) begin
         chk("t6_addr0", 64'(addr_log[0]), 64'd400);
         chk("t6_addr1", 64'(addr_log[1]), 64'd401);
      end
      $display("t6: ignored start, last beat edge offset %0d", last_xfer_edge - start_edge);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
